rom_stream_reader: RTL and testbench
====================================

ROM_STREAM_READER -- requirements
Module: rom_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, ROM word and stream data width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 10, ROM word-address width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries; legal values are powers of two, at least 4.
REQ-004 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rstn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port i_start, input, 1, a one-cycle request to begin a transfer.
REQ-007 SHALL have port i_base_addr, input, ADDRESS_WIDTH, the first ROM word address, sampled with i_start.
REQ-008 SHALL have port i_count, input, ADDRESS_WIDTH+1, the number of words to read, sampled with i_start.
REQ-009 SHALL have port o_busy, output, 1, high from the accepted start until done.
REQ-010 SHALL have port o_done, output, 1, a one-cycle completion pulse.
REQ-011 SHALL have port o_rom_address, output, ADDRESS_WIDTH, the address to the synchronous ROM.
REQ-012 SHALL have port i_rom_read_data, input, DATA_WIDTH, the ROM read data, valid 2 cycles after its address.
REQ-013 SHALL have port o_data, output, DATA_WIDTH, the stream data.
REQ-014 SHALL have port o_valid, output, 1, the stream valid signal.
REQ-015 SHALL have port i_ready, input, 1, the stream ready signal.
REQ-016 SHALL have port o_last, output, 1, marking the final word of the transfer.

Function
REQ-017 SHALL implement states IDLE, FETCH and DRAIN.
REQ-018 In IDLE, i_start SHALL latch i_base_addr and i_count; a nonzero count moves to FETCH with o_busy=1 next cycle.
REQ-019 i_start with i_count==0 SHALL stay in IDLE, issue no ROM reads and pulse o_done the next cycle.
REQ-020 i_start SHALL be ignored while o_busy=1.
REQ-021 ROM latency SHALL be fixed at 2: data for the address driven in cycle t is captured from i_rom_read_data at the rising edge ending cycle t+2, using a 2-stage in-flight valid/last shift pipeline.
REQ-022 In FETCH, an address SHALL issue in a cycle only when (FIFO occupancy + in-flight count) < FIFO_DEPTH; captured data never finds the FIFO full.
REQ-023 Each issue SHALL increment o_rom_address modulo 2^ADDRESS_WIDTH (wrap from all-ones to 0) and decrement the remaining count.
REQ-024 When the last address issues, FETCH SHALL go to DRAIN; the in-flight entry for that address carries last=1.
REQ-025 In DRAIN, when the in-flight count is 0, the FIFO is empty and the final beat handshake occurs, the block SHALL assert o_done for one cycle, drop o_busy, and return to IDLE.
REQ-026 The stream SHALL transfer a beat on o_valid&&i_ready; while o_valid=1 and i_ready=0, o_data and o_last SHALL hold stable.
REQ-027 o_valid SHALL equal FIFO non-empty; words SHALL exit in address-issue order with no loss or duplication.
REQ-028 A simultaneous FIFO push (capture) and pop (handshake) in one cycle SHALL leave occupancy unchanged.
REQ-029 o_last SHALL be 1 only on the final word of a transfer.
REQ-030 Full throughput SHALL be 1 word/cycle when i_ready is held high; first o_valid SHALL be 4 cycles after i_start.
REQ-031 o_rom_address SHALL hold its last value when not issuing.

Reset
REQ-032 While i_rstn=0, the block SHALL be in IDLE with o_busy, o_done, o_valid, o_last, o_rom_address and o_data all 0, the FIFO empty and the in-flight pipeline cleared.
REQ-033 Reset asserted mid-transfer SHALL abort it immediately, with no o_done and no further o_valid until a new start.

Verification
REQ-034 Basic read: ROM[i]=i*3; start base=5, count=4, i_ready=1 -> beats 15,18,21,24 on consecutive cycles, o_last on 24, one o_done pulse.
REQ-035 Backpressure: base=0, count=16, i_ready toggled randomly or held low for 10 cycles -> all 16 words in order, at most FIFO_DEPTH outstanding, data stable while stalled.
REQ-036 Wrap: ADDRESS_WIDTH=10, base=1022, count=4 -> addresses 1022,1023,0,1 issued and streamed in order.
REQ-037 Zero and ignored start: count=0 -> o_done after 1 cycle with no o_valid; a second i_start during a busy transfer -> no effect on the stream.
REQ-038 Reset mid-operation: deassert i_rstn after 3 beats of a 10-word transfer -> outputs 0 immediately, no o_done; a new start afterwards completes normally.

Source files
------------

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: streams a block of words from a 2-cycle-latency synchronous ROM
// through a small FIFO onto a valid/ready interface.
module rom_stream_reader #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 10,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_start,
  input  logic [ADDRESS_WIDTH-1:0] i_base_addr,
  input  logic [ADDRESS_WIDTH:0]   i_count,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [ADDRESS_WIDTH-1:0] o_rom_address,
  input  logic [DATA_WIDTH-1:0]    i_rom_read_data,
  output logic [DATA_WIDTH-1:0]    o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_last
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH:0]   rem_q, rem_d;
  logic                     busy_q, busy_d, done_q, done_d;
  logic [1:0]               pv_q, pv_d, pl_q, pl_d;
  logic [DATA_WIDTH-1:0]    mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    mem_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]    last_q, last_d;
  logic [PW-1:0]            wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]              occ_q, occ_d;
  logic [PW+1:0]            fill;
  logic                     issue, push, pop, final_addr;
  // Reserve a FIFO slot for every read in flight so a capture never overflows.
  assign fill       = (PW+2)'(occ_q) + (PW+2)'(pv_q[0]) + (PW+2)'(pv_q[1]);
  assign issue      = (state_q == FETCH) && (fill < (PW+2)'(FIFO_DEPTH));
  assign final_addr = rem_q == (ADDRESS_WIDTH+1)'(1);
  assign push       = pv_q[1];
  assign pop        = o_valid && i_ready;
  assign o_valid    = occ_q != '0;
  assign o_data     = o_valid ? mem_q[rd_q] : '0;
  assign o_last     = o_valid && last_q[rd_q];
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_rom_address = addr_q;
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    addr_d  = issue ? addr_q + 1'b1 : addr_q;
    rem_d   = issue ? rem_q - 1'b1 : rem_q;
    pv_d    = {pv_q[0], issue};
    pl_d    = {pl_q[0], issue && final_addr};
    mem_d   = mem_q;
    last_d  = last_q;
    wr_d    = push ? wr_q + 1'b1 : wr_q;
    rd_d    = pop ? rd_q + 1'b1 : rd_q;
    occ_d   = occ_q + (PW+1)'(push) - (PW+1)'(pop);
    if (push) begin
      mem_d[wr_q]  = i_rom_read_data;
      last_d[wr_q] = pl_q[1];
    end
    if (issue && final_addr) state_d = DRAIN;
    if (state_q == IDLE && i_start) begin
      if (i_count == '0) done_d = 1'b1;
      else begin
        state_d = FETCH;
        busy_d  = 1'b1;
        addr_d  = i_base_addr;
        rem_d   = i_count;
      end
    end
    if (state_q == DRAIN && pop && o_last) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      rem_q   <= '0;
      pv_q    <= '0;
      pl_q    <= '0;
      last_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      pv_q    <= pv_d;
      pl_q    <= pl_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      occ_q   <= occ_d;
    end
  end
  // Storage needs no reset: o_data is forced to 0 whenever the FIFO is empty.
  always_ff @(posedge i_clk) mem_q <= mem_d;
endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader: scoreboard bench for rom_stream_reader with a 2-cycle ROM model.
module tb_rom_stream_reader;
  logic        i_clk = 0, i_rstn = 0, i_start = 0, i_ready = 1;
  logic [9:0]  i_base_addr = '0;
  logic [10:0] i_count = '0;
  logic        o_busy, o_done, o_valid, o_last;
  logic [9:0]  o_rom_address;
  logic [31:0] i_rom_read_data, o_data, rd1;
  logic [31:0] rom [1024];
  logic [32:0] sb [$];
  logic [32:0] held, e;
  logic        stall = 0;
  int errors = 0, checks = 0, cyc = 0, start_cyc = 0, first_cyc = -1, last_cyc = 0;
  int beats = 0, done_n = 0, vcnt = 0;

  rom_stream_reader dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_count(i_count), .o_busy(o_busy), .o_done(o_done), .o_rom_address(o_rom_address),
    .i_rom_read_data(i_rom_read_data), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_last(o_last)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;
  always @(posedge i_clk) begin
    rd1             <= rom[o_rom_address];
    i_rom_read_data <= rd1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge i_clk) begin
    if (i_rstn) begin
      if (stall) chk("stable", {o_valid, o_last, o_data}, {1'b1, held});
      if (o_valid) vcnt++;
      if (o_valid && first_cyc < 0) first_cyc = cyc;
      if (o_done) done_n++;
      if (o_valid && i_ready) begin
        beats++;
        last_cyc = cyc;
        if (sb.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          e = sb.pop_front();
          chk("data", o_data, e[31:0]);
          chk("last", o_last, e[32]);
        end
      end
      stall = o_valid && !i_ready;
      held  = {o_last, o_data};
    end else stall = 0;
  end

  task automatic start(input int base, input int cnt);
    @(posedge i_clk); #1;
    i_start = 1; i_base_addr = 10'(base); i_count = 11'(cnt);
    start_cyc = cyc; first_cyc = -1;
    for (int k = 0; k < cnt; k++) sb.push_back({k == cnt - 1, rom[(base + k) % 1024]});
    @(posedge i_clk); #1;
    i_start = 0;
  endtask

  // mode 0: ready high, 1: random ready, 2: ready low for 10 cycles then high
  task automatic run(input int mode, input int budget);
    int d0, n;
    d0 = done_n; n = 0;
    while (done_n == d0 && n < budget) begin
      @(posedge i_clk); #1;
      n++;
      i_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'(($urandom % 2)) : (n > 10);
    end
    chk("done_seen", done_n != d0, 1);
    chk("queue_empty", sb.size(), 0);
    i_ready = 1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_last"}, o_last, 0);
    chk({tag, "_addr"}, o_rom_address, 0);
    chk({tag, "_data"}, o_data, 0);
  endtask

  initial begin
    int d0, b0, v0, n;
    for (int i = 0; i < 1024; i++) rom[i] = 32'(i * 3);
    repeat (3) @(posedge i_clk);
    #1 check_idle_outputs("reset");
    i_rstn = 1;
    repeat (2) @(posedge i_clk);

    d0 = done_n;
    start(5, 4);
    chk("busy_after_start", o_busy, 1);
    run(0, 50);
    chk("first_latency", first_cyc - start_cyc, 4);
    chk("burst_span", last_cyc - first_cyc, 3);
    chk("done_pulses", done_n - d0, 1);
    @(negedge i_clk);
    chk("busy_after_done", o_busy, 0);

    i_ready = 0;
    start(0, 16);
    run(1, 400);
    i_ready = 0;
    start(100, 8);
    run(2, 200);

    start(1022, 4);
    run(0, 50);
    chk("wrap_span", last_cyc - first_cyc, 3);

    d0 = done_n; v0 = vcnt;
    start(0, 0);
    @(negedge i_clk);
    chk("zero_done", o_done, 1);
    chk("zero_busy", o_busy, 0);
    repeat (6) @(posedge i_clk);
    #1 chk("zero_no_valid", vcnt - v0, 0);
    chk("zero_done_pulses", done_n - d0, 1);

    b0 = beats;
    start(200, 6);
    repeat (2) @(posedge i_clk);
    #1 i_start = 1; i_base_addr = 10'd500; i_count = 11'd3;
    @(posedge i_clk); #1 i_start = 0;
    run(0, 50);
    repeat (10) @(posedge i_clk);
    #1 chk("ignored_start_beats", beats - b0, 6);

    b0 = beats;
    start(0, 10);
    n = 0;
    while (beats - b0 < 3 && n < 50) begin @(posedge i_clk); #1 n++; end
    chk("reached_3_beats", beats - b0 >= 3, 1);
    d0 = done_n;
    i_rstn = 0;
    #1 check_idle_outputs("abort");
    sb.delete();
    repeat (2) @(posedge i_clk);
    #1 i_rstn = 1;
    v0 = vcnt;
    repeat (10) @(posedge i_clk);
    #1 chk("abort_no_valid", vcnt - v0, 0);
    chk("abort_no_done", done_n - d0, 0);
    start(50, 5);
    run(0, 50);
    chk("restart_span", last_cyc - first_cyc, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
